// File: rtl/nibble_packer.sv
// Packs pairs of 4-bit results into bytes (first nibble in bits 3:0) and queues
// them in a small circular FIFO with sticky overflow reporting.
module nibble_packer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    pi_nib,
    input  logic          pi_nib_vld,
    input  logic          pi_flush,
    input  logic          pi_byte_rdy,
    output logic [7:0]    po_byte,
    output logic          po_byte_vld,
    output logic [CW-1:0] po_cnt,
    output logic          po_full,
    output logic          po_ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      held_low_q, held_low_d;
    logic            push;
    logic [7:0]      push_data;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full_q;
    logic            ovf_q;
    logic            pop;
    logic            wr_en;

    // Packer FSM: next state, held nibble and push request
    always_comb begin
        state_d    = state_q;
        held_low_d = held_low_q;
        push       = 1'b0;
        push_data  = '0;
        unique case (state_q)
            ST_LOW: begin
                if (pi_nib_vld && !pi_flush) begin
                    held_low_d = pi_nib;
                    state_d    = ST_HIGH;
                end else if (pi_nib_vld && pi_flush) begin
                    push      = 1'b1;
                    push_data = {4'h0, pi_nib};
                end
            end
            ST_HIGH: begin
                if (pi_nib_vld) begin
                    push      = 1'b1;
                    push_data = {pi_nib, held_low_q};
                    state_d   = ST_LOW;
                end else if (pi_flush) begin
                    push      = 1'b1;
                    push_data = {4'h0, held_low_q};
                    state_d   = ST_LOW;
                end
            end
            default: state_d = ST_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOW;
            held_low_q <= '0;
        end else begin
            state_q    <= state_d;
            held_low_q <= held_low_d;
        end
    end

    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the new byte lands at the tail.
    assign pop   = (cnt_q != '0) && pi_byte_rdy;
    assign wr_en = push && (!full_q || pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && full_q && !pop) begin
                ovf_q <= 1'b1;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CW'(DEPTH));
        end
    end

    // Storage is cleared on reset so the head byte reads 8'h00 while reset holds
    assign po_byte     = mem[rd_ptr_q];
    assign po_byte_vld = (cnt_q != '0);
    assign po_cnt      = cnt_q;
    assign po_full     = full_q;
    assign po_ovf      = ovf_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Scenario bench for nibble_packer: a reference packer/FIFO model queues the
// expected bytes as stimulus is driven; a negedge monitor pops them on handshakes.
module tb_nibble_packer;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    pi_nib = '0;
    logic          pi_nib_vld = 1'b0;
    logic          pi_flush = 1'b0;
    logic          pi_byte_rdy = 1'b0;
    logic [7:0]    po_byte;
    logic          po_byte_vld;
    logic [CW-1:0] po_cnt;
    logic          po_full;
    logic          po_ovf;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_pop;
    int         m_cnt = 0;
    logic       m_state = 1'b0;
    logic [3:0] m_held = '0;
    logic       m_ovf = 1'b0;

    nibble_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pi_nib      (pi_nib),
        .pi_nib_vld  (pi_nib_vld),
        .pi_flush    (pi_flush),
        .pi_byte_rdy (pi_byte_rdy),
        .po_byte     (po_byte),
        .po_byte_vld (po_byte_vld),
        .po_cnt      (po_cnt),
        .po_full     (po_full),
        .po_ovf      (po_ovf)
    );

    always #5 clk = ~clk;

    // Scoreboard: each accepted handshake must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && po_byte_vld && pi_byte_rdy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got byte %02h, expected no valid byte", po_byte);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                if (po_byte !== e) begin
                    n_err++;
                    $display("FAIL pop_data: got %02h, expected %02h", po_byte, e);
                end
                last_pop = po_byte;
                n_pop++;
            end
        end
    end

    // Applies one cycle of inputs, advances the reference model, waits past the edge
    task automatic drive(input logic vld, input logic [3:0] nib, input logic flush, input logic rdy);
        logic       mpush;
        logic [7:0] mdata;
        logic       mpop;
        pi_nib_vld  = vld;
        pi_nib      = nib;
        pi_flush    = flush;
        pi_byte_rdy = rdy;
        mpush = 1'b0;
        mdata = '0;
        mpop  = (m_cnt > 0) && rdy;
        if (!m_state) begin
            if (vld && !flush) begin
                m_held  = nib;
                m_state = 1'b1;
            end else if (vld && flush) begin
                mpush = 1'b1;
                mdata = {4'h0, nib};
            end
        end else begin
            if (vld) begin
                mpush = 1'b1;
                mdata = {nib, m_held};
                m_state = 1'b0;
            end else if (flush) begin
                mpush = 1'b1;
                mdata = {4'h0, m_held};
                m_state = 1'b0;
            end
        end
        if (mpush) begin
            if (m_cnt < DEPTH || mpop) exp_q.push_back(mdata);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        m_cnt = m_cnt + ((mpush && (m_cnt < DEPTH || mpop)) ? 1 : 0) - (mpop ? 1 : 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && m_cnt > 0; i++) drive(1'b0, 4'h0, 1'b0, 1'b1);
        pi_byte_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pi_nib_vld = 1'b0;
        pi_flush = 1'b0;
        #1;
        exp_q.delete();
        m_cnt = 0;
        m_state = 1'b0;
        m_held = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({po_byte, po_byte_vld, po_cnt, po_full, po_ovf} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got byte=%02h vld=%b cnt=%0d full=%b ovf=%b, expected 00/0/0/0/0",
                     po_byte, po_byte_vld, po_cnt, po_full, po_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pair();
        drive(1'b1, 4'h3, 1'b0, 1'b1);
        n_cmp++;
        if (po_byte_vld !== 1'b0) begin
            n_err++;
            $display("FAIL pair_half: got vld=%b, expected 0", po_byte_vld);
        end
        drive(1'b1, 4'hA, 1'b0, 1'b1);
        n_cmp++;
        if (po_byte_vld !== 1'b1 || po_byte !== 8'hA3) begin
            n_err++;
            $display("FAIL pair_out: got vld=%b byte=%02h, expected 1/a3", po_byte_vld, po_byte);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        n_cmp++;
        if (po_byte_vld !== 1'b0 || po_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL pair_one_cycle: got vld=%b cnt=%0d, expected 0/0", po_byte_vld, po_cnt);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        n_cmp++;
        if (po_cnt !== 3'd4 || po_full !== 1'b1 || po_ovf !== 1'b1 || m_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flags: got cnt=%0d full=%b ovf=%b, expected 4/1/1", po_cnt, po_full, po_ovf);
        end
        n_cmp++;
        if (po_byte !== 8'h10) begin
            n_err++;
            $display("FAIL ovf_head: got %02h, expected 10", po_byte);
        end
        drain();
        n_cmp++;
        if (po_cnt !== 3'd0 || exp_q.size() != 0 || po_ovf !== 1'b1 || last_pop !== 8'h76) begin
            n_err++;
            $display("FAIL ovf_drain: got cnt=%0d left=%0d ovf=%b last=%02h, expected 0/0/1/76",
                     po_cnt, exp_q.size(), po_ovf, last_pop);
        end
        do_reset();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) drive(1'b1, 4'(i + 1), 1'b0, 1'b0);
        n_cmp++;
        if (po_full !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_full: got full=%b, expected 1", po_full);
        end
        drive(1'b1, 4'hC, 1'b0, 1'b0);
        drive(1'b1, 4'hD, 1'b0, 1'b1);
        n_cmp++;
        if (po_cnt !== 3'd4 || po_ovf !== 1'b0 || po_full !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_cnt: got cnt=%0d ovf=%b full=%b, expected 4/0/1", po_cnt, po_ovf, po_full);
        end
        drain();
        n_cmp++;
        if (last_pop !== 8'hDC || po_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL fpp_order: got last=%02h cnt=%0d, expected dc/0", last_pop, po_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 4'h7, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        n_cmp++;
        if (po_cnt !== 3'd1 || po_byte !== 8'h07) begin
            n_err++;
            $display("FAIL flush_half: got cnt=%0d byte=%02h, expected 1/07", po_cnt, po_byte);
        end
        drive(1'b1, 4'h5, 1'b1, 1'b0);
        n_cmp++;
        if (po_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL flush_with_nib: got cnt=%0d, expected 2", po_cnt);
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        n_cmp++;
        if (po_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL flush_idle: got cnt=%0d, expected 2", po_cnt);
        end
        drain();
        n_cmp++;
        if (last_pop !== 8'h05 || po_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL flush_drain: got last=%02h cnt=%0d, expected 05/0", last_pop, po_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(1'b1, 4'hE, 1'b0, 1'b0);
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (po_cnt !== 3'd0 || po_byte_vld !== 1'b0 || po_ovf !== 1'b0 || po_byte !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_now: got cnt=%0d vld=%b ovf=%b byte=%02h, expected 0/0/0/00",
                     po_cnt, po_byte_vld, po_ovf, po_byte);
        end
        do_reset();
        drive(1'b1, 4'h1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0);
        n_cmp++;
        if (po_cnt !== 3'd1 || po_byte !== 8'h21) begin
            n_err++;
            $display("FAIL rstmid_pair: got cnt=%0d byte=%02h, expected 1/21", po_cnt, po_byte);
        end
        drain();
    endtask

    task automatic test_wrap();
        int start_pops;
        start_pops = n_pop;
        for (int i = 0; i < 24; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, (i % 3) != 0);
        drain();
        n_cmp++;
        if (n_pop - start_pops != 12 || po_ovf !== 1'b0 || po_cnt !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap: got pops=%0d ovf=%b cnt=%0d left=%0d, expected 12/0/0/0",
                     n_pop - start_pops, po_ovf, po_cnt, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
